// File: rtl/event_stretch.sv
// event_stretch: turns single-cycle event pulses into human-visible LED pulses.
// Each accepted event yields one ON_CYCLES-long LED window followed by a
// GAP_CYCLES-long dark gap. Events arriving while a pulse is in progress are
// queued in a saturating pending counter; a sticky overflow flag records any
// event dropped because the queue was full.
module event_stretch #(
    parameter int unsigned ON_CYCLES  = 10_000_000,
    parameter int unsigned GAP_CYCLES = 5_000_000,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              evt_in,
    input  logic              clr_ovf,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              r_led;

    logic              w_timer_zero;
    logic              w_gap_end;
    logic              w_pend_zero;
    logic              w_inc;
    logic              w_dec;

    // Decode the events that drive the pending counter this cycle.
    // An event on the final gap edge with nothing queued starts the next
    // pulse directly, so it is not counted as a queued event.
    always_comb begin
        w_timer_zero = (r_timer == '0);
        w_pend_zero  = (r_pend == '0);
        w_gap_end    = (r_state == S_GAP) && w_timer_zero;
        w_inc        = evt_in && (r_state != S_IDLE) && !(w_gap_end && w_pend_zero);
        w_dec        = w_gap_end && !w_pend_zero;
    end

    // Next-state and timer logic for the IDLE -> ON -> GAP sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        unique case (r_state)
            S_IDLE: begin
                if (evt_in) begin
                    w_state_nxt = S_ON;
                    w_timer_nxt = ON_LOAD;
                end
            end
            S_ON: begin
                if (!w_timer_zero) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else begin
                    w_state_nxt = S_GAP;
                    w_timer_nxt = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (!w_timer_zero) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else if (!w_pend_zero || evt_in) begin
                    w_state_nxt = S_ON;
                    w_timer_nxt = ON_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Saturating pending counter and sticky overflow; a new overflow wins
    // over a simultaneous clear.
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf && !clr_ovf;
        if (w_inc && !w_dec) begin
            if (r_pend == PEND_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_pend_nxt = r_pend + 1'b1;
            end
        end else if (w_dec && !w_inc) begin
            w_pend_nxt = r_pend - 1'b1;
        end
    end

    // State, timer, counters and the registered LED output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
            r_led   <= (w_state_nxt == S_ON);
        end
    end

    assign led_out  = r_led;
    assign busy     = (r_state != S_IDLE);
    assign pending  = r_pend;
    assign overflow = r_ovf;

endmodule
